boreal_gate_policy_mmio: RTL and testbench
==========================================

Name: boreal_gate_policy_mmio

Overview:
MMIO responder for the Gate policy register window on the SoC cpu_req/cpu_resp bus. It accepts single-beat read and write requests and returns one response pulse per accepted request, carrying read data or an error. It holds the Gate's allow mask, rate limit, rate window, policy hash and clamp bounds, and drives them to the Gate datapath. A write-once lock freezes the policy after boot.

Parameters:
BASE_ADDR, 32'h1004_0000, byte base of the 256-byte window (addr[7:0] is the offset).
N_CLAMP, 4, number of clamp classes (1..16).
RESP_LAT, 1, cycles from request acceptance to the response pulse (1..15).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cpu_req_valid  in  1  request strobe; one cycle per request
cpu_req_we  in  1  1 = write, 0 = read
cpu_req_addr  in  32  byte address
cpu_req_wdata  in  32  write data
cpu_req_wstrb  in  4  byte enables for writes
cpu_resp_valid  out  1  one-cycle response pulse
cpu_resp_rdata  out  32  read data; 0 on writes and on errors
cpu_resp_err  out  1  error flag, valid with cpu_resp_valid
allow_mask  out  64  {ALLOW1, ALLOW0}
rate_limit  out  32  RATE_LIMIT
rate_window  out  32  RATE_WINDOW
policy_hash  out  32  POLICY_HASH
clamp_min_flat  out  32*N_CLAMP  class c occupies bits [32c+31:32c]
clamp_max_flat  out  32*N_CLAMP  same packing as clamp_min_flat
policy_locked  out  1  CTRL.LOCK
policy_update  out  1  one-cycle pulse after each committed policy write

Behaviour:
- Reset (async assert, sync release): cpu_resp_valid=0, rdata=0, err=0, FSM=IDLE.
  - Policy registers reset to 0, except every CLAMP_MAX resets to 32'hFFFF_FFFF.
  - LOCK=0, DROP=0, policy_update=0.
  - Reset mid-transaction discards the pending response and no pulse is produced.
- Register map (offset):
  - 0x00 ALLOW0, 0x04 ALLOW1, 0x08 RATE_LIMIT, 0x0C RATE_WINDOW, 0x10 POLICY_HASH.
  - 0x14 CTRL: bit0 LOCK, write-1-to-set, cleared only by reset; reads back bit0.
  - 0x18 STATUS, read-only: bit0 LOCK, bit1 DROP (sticky). Writing STATUS with wdata[1]=1 clears DROP; this is the only legal STATUS write.
  - 0x20+8c CLAMP_MIN c and 0x24+8c CLAMP_MAX c, for c < N_CLAMP.
  - All other offsets are unmapped.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on a posedge with cpu_req_valid=1, accept the request, then go to WAIT if RESP_LAT>1, otherwise RESP.
  - WAIT: count RESP_LAT-1 cycles, then go to RESP.
  - RESP: cpu_resp_valid=1 for exactly one cycle, then return to IDLE. A new request can be accepted on the cycle after RESP (minimum spacing is RESP_LAT+1 cycles).
- At the acceptance edge, decode, execute and latch the result. Read data is snapshotted at this edge, so later writes do not alter it.
- Error (err=1, no state change, rdata=0) when any of the following holds:
  - addr[31:8] != BASE_ADDR[31:8];
  - addr[1:0] != 0;
  - offset is unmapped;
  - write to STATUS with wdata[1]=0;
  - write to any policy register or CTRL while LOCK=1;
  - write with wstrb=0.
- Writes merge by byte: for each byte i, reg[8i+7:8i] takes wdata[8i+7:8i] if wstrb[i]=1, else keeps its old value.
- policy_update pulses on the cycle after a successful commit to ALLOW/RATE/HASH/CLAMP/CTRL. It does not pulse on STATUS writes or reads.
- A cpu_req_valid seen in WAIT or RESP is dropped: no response, sets DROP, no register effect.
- Reads never have side effects. Policy outputs are driven directly from the registers.
- An erroring read returns rdata=0.

Test Plan:
- Reset, then read 0x1004_0024 → err=0, rdata=FFFF_FFFF, with resp_valid high for exactly 1 cycle, RESP_LAT cycles after acceptance; all policy outputs 0 except clamp_max_flat all ones.
- Write 0x1004_0010=A5A5_0001 with wstrb=F, then read it back → A5A5_0001, policy_hash=A5A5_0001, policy_update pulsed once. Then write 0x1004_0010=0000_00FF with wstrb=1 → read returns A5A5_00FF.
- Access 0x2000_0000, 0x1004_0002 and 0x1004_0040 (the last with N_CLAMP=4) → err=1, rdata=0, no register change.
- Write ALLOW0=0001_0000, then CTRL=1 → policy_locked=1. Next, write ALLOW0=0 → err=1 and ALLOW0 unchanged. Then read STATUS → 0000_0001.
- With RESP_LAT=3, issue a second request 1 cycle after the first → exactly one response, and STATUS reads 3 (LOCK=1 and DROP=1 after the previous scenario). Writing STATUS=2 clears DROP; writing STATUS=0 returns err.
- Assert rst during WAIT → no cpu_resp_valid pulse; registers are at reset values afterwards.

Source files
------------

// File: rtl/boreal_gate_policy_mmio_if.sv
// Single-beat cpu_req/cpu_resp bus between the SoC and the Gate policy window.
// The master issues requests; the slave returns one response pulse per accepted request.
interface boreal_gate_policy_mmio_if;
  logic        cpu_req_valid;
  logic        cpu_req_we;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic [3:0]  cpu_req_wstrb;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic        cpu_resp_err;

  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    input  cpu_resp_valid, cpu_resp_rdata, cpu_resp_err
  );

  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_wstrb,
    output cpu_resp_valid, cpu_resp_rdata, cpu_resp_err
  );
endinterface

// File: rtl/boreal_gate_policy_mmio.sv
// Gate policy register window: decodes single-beat MMIO accesses, holds the policy
// registers driven to the Gate datapath, and freezes them once LOCK is set.
module boreal_gate_policy_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h1004_0000,
  parameter int          N_CLAMP   = 4,
  parameter int          RESP_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  boreal_gate_policy_mmio_if.slave bus,
  output logic [63:0]            allow_mask,
  output logic [31:0]            rate_limit,
  output logic [31:0]            rate_window,
  output logic [31:0]            policy_hash,
  output logic [32*N_CLAMP-1:0]  clamp_min_flat,
  output logic [32*N_CLAMP-1:0]  clamp_max_flat,
  output logic                   policy_locked,
  output logic                   policy_update
);

  // Register file slots: 0..4 ALLOW0..POLICY_HASH, then MIN/MAX pairs per clamp class.
  localparam int NREG = 5 + 2 * N_CLAMP;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_regs [NREG];
  logic        r_lock, r_drop, r_update, r_err;
  logic [31:0] r_rdata;

  logic        w_accept, w_base_ok, w_align_ok, w_is_pol, w_is_ctrl, w_is_stat;
  logic        w_err, w_commit_pol, w_commit_ctrl, w_clr_drop;
  logic [5:0]  w_word, w_idx;
  logic [31:0] w_cur, w_merge, w_rd_value;

  assign w_accept = (r_state == IDLE) && bus.cpu_req_valid;

  always_comb begin
    w_word     = bus.cpu_req_addr[7:2];
    w_base_ok  = bus.cpu_req_addr[31:8] == BASE_ADDR[31:8];
    w_align_ok = bus.cpu_req_addr[1:0] == 2'b00;
    w_is_ctrl  = w_word == 6'd5;
    w_is_stat  = w_word == 6'd6;
    w_is_pol   = 1'b0;
    w_idx      = 6'd0;
    if (w_word < 6'd5) begin
      w_is_pol = 1'b1;
      w_idx    = w_word;
    end else if (w_word >= 6'd8 && 32'(w_word) < 32'(8 + 2 * N_CLAMP)) begin
      w_is_pol = 1'b1;
      w_idx    = w_word - 6'd3;
    end

    w_cur = '0;
    for (int k = 0; k < NREG; k++) begin
      if (w_idx == 6'(k)) w_cur = r_regs[k];
    end
    for (int i = 0; i < 4; i++) begin
      w_merge[8*i +: 8] = bus.cpu_req_wstrb[i] ? bus.cpu_req_wdata[8*i +: 8] : w_cur[8*i +: 8];
    end

    w_rd_value = w_cur;
    if (w_is_ctrl) w_rd_value = {31'd0, r_lock};
    if (w_is_stat) w_rd_value = {30'd0, r_drop, r_lock};

    w_err = !w_base_ok || !w_align_ok || !(w_is_pol || w_is_ctrl || w_is_stat);
    if (bus.cpu_req_we) begin
      if (bus.cpu_req_wstrb == 4'd0)                 w_err = 1'b1;
      if (w_is_stat && !bus.cpu_req_wdata[1])        w_err = 1'b1;
      if (r_lock && (w_is_pol || w_is_ctrl))         w_err = 1'b1;
    end

    w_commit_pol  = w_accept && bus.cpu_req_we && !w_err && w_is_pol;
    w_commit_ctrl = w_accept && bus.cpu_req_we && !w_err && w_is_ctrl;
    w_clr_drop    = w_accept && bus.cpu_req_we && !w_err && w_is_stat;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.cpu_req_valid) w_state_next = (RESP_LAT > 1) ? WAIT : RESP;
      WAIT:    if (r_cnt == 4'(RESP_LAT - 2)) w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_lock   <= 1'b0;
      r_drop   <= 1'b0;
      r_update <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= 32'd0;
      for (int k = 0; k < NREG; k++) begin
        r_regs[k] <= (k >= 5 && ((k - 5) % 2) == 1) ? 32'hFFFF_FFFF : 32'd0;
      end
    end else begin
      r_state  <= w_state_next;
      r_update <= w_commit_pol || w_commit_ctrl;
      if (w_accept) begin
        r_cnt   <= 4'd0;
        r_err   <= w_err;
        r_rdata <= (w_err || bus.cpu_req_we) ? 32'd0 : w_rd_value;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 4'd1;
      end
      // Requests arriving while a response is pending are discarded but remembered.
      if (r_state != IDLE && bus.cpu_req_valid) r_drop <= 1'b1;
      else if (w_clr_drop)                      r_drop <= 1'b0;
      if (w_commit_ctrl && bus.cpu_req_wstrb[0] && bus.cpu_req_wdata[0]) r_lock <= 1'b1;
      for (int k = 0; k < NREG; k++) begin
        if (w_commit_pol && w_idx == 6'(k)) r_regs[k] <= w_merge;
      end
    end
  end

  assign bus.cpu_resp_valid = (r_state == RESP);
  assign bus.cpu_resp_rdata = (r_state == RESP) ? r_rdata : 32'd0;
  assign bus.cpu_resp_err   = (r_state == RESP) && r_err;

  assign allow_mask    = {r_regs[1], r_regs[0]};
  assign rate_limit    = r_regs[2];
  assign rate_window   = r_regs[3];
  assign policy_hash   = r_regs[4];
  assign policy_locked = r_lock;
  assign policy_update = r_update;

  generate
    for (genvar gi = 0; gi < N_CLAMP; gi++) begin : g_clamp
      assign clamp_min_flat[32*gi +: 32] = r_regs[5 + 2*gi];
      assign clamp_max_flat[32*gi +: 32] = r_regs[6 + 2*gi];
    end
  endgenerate

endmodule

// File: tb/tb_boreal_gate_policy_mmio.sv
// Randomised and directed MMIO traffic against a whole-window reference model;
// responses are checked by a scoreboard monitor decoupled from the driver.
module tb_boreal_gate_policy_mmio;
  localparam int L  = 3;
  localparam int NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boreal_gate_policy_mmio_if bus();

  logic [63:0]     allow_mask;
  logic [31:0]     rate_limit, rate_window, policy_hash;
  logic [32*NC-1:0] clamp_min_flat, clamp_max_flat;
  logic            policy_locked, policy_update;

  boreal_gate_policy_mmio #(.BASE_ADDR(32'h1004_0000), .N_CLAMP(NC), .RESP_LAT(L)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .allow_mask(allow_mask), .rate_limit(rate_limit), .rate_window(rate_window),
    .policy_hash(policy_hash), .clamp_min_flat(clamp_min_flat), .clamp_max_flat(clamp_max_flat),
    .policy_locked(policy_locked), .policy_update(policy_update)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: the window as 64 words plus the LOCK/DROP flags.
  logic [31:0] m_win [64];
  bit          m_lock, m_drop;
  int          m_upd = 0;

  function automatic bit is_pol(input int w);
    return (w < 5) || (w >= 8 && w < 8 + 2*NC);
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 64; w++) m_win[w] = (w >= 8 && w < 8 + 2*NC && (w % 2) == 1) ? 32'hFFFF_FFFF : 32'd0;
    m_lock = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, output logic [31:0] rd, output bit er);
    int w;
    w  = int'(a[7:2]);
    er = !(a[31:8] == 24'h100400 && a[1:0] == 2'b00 && (is_pol(w) || w == 5 || w == 6));
    if (!er && we) begin
      if (st == 4'd0)            er = 1'b1;
      if (w == 6 && !wd[1])      er = 1'b1;
      if (w != 6 && m_lock)      er = 1'b1;
    end
    rd = 32'd0;
    if (!er) begin
      if (!we) begin
        rd = (w == 5) ? {31'd0, m_lock} : (w == 6) ? {30'd0, m_drop, m_lock} : m_win[w];
      end else if (w == 6) begin
        m_drop = 1'b0;
      end else if (w == 5) begin
        if (st[0] && wd[0]) m_lock = 1'b1;
        m_upd++;
      end else begin
        for (int i = 0; i < 4; i++) if (st[i]) m_win[w][8*i +: 8] = wd[8*i +: 8];
        m_upd++;
      end
    end
  endtask

  typedef struct { logic [31:0] rd; logic er; int cyc; } exp_t;
  exp_t q[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int upd_cnt = 0;
  int n_resp  = 0;
  bit prev_v  = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (bus.cpu_resp_valid) begin
      if (prev_v) chk("resp_one_cycle", 128'(prev_v), 128'(0));
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp actual=rdata %h err %0d expected=no response", bus.cpu_resp_rdata, bus.cpu_resp_err);
      end else begin
        e = q.pop_front();
        chk("resp_rdata", bus.cpu_resp_rdata, e.rd);
        chk("resp_err", 128'(bus.cpu_resp_err), 128'(e.er));
        chk("resp_latency", 128'(cyc), 128'(e.cyc));
        n_resp++;
        $display("resp %0d: rdata=%h err=%0d cyc=%0d", n_resp, bus.cpu_resp_rdata, bus.cpu_resp_err, cyc);
      end
    end
    if (policy_update) upd_cnt++;
    prev_v = bus.cpu_resp_valid;
  end

  task automatic chk_outputs();
    logic [32*NC-1:0] emin, emax;
    for (int c = 0; c < NC; c++) begin
      emin[32*c +: 32] = m_win[8 + 2*c];
      emax[32*c +: 32] = m_win[9 + 2*c];
    end
    chk("allow_mask", allow_mask, {m_win[1], m_win[0]});
    chk("rate_limit", rate_limit, m_win[2]);
    chk("rate_window", rate_window, m_win[3]);
    chk("policy_hash", policy_hash, m_win[4]);
    chk("clamp_min", clamp_min_flat, emin);
    chk("clamp_max", clamp_max_flat, emax);
    chk("policy_locked", 128'(policy_locked), 128'(m_lock));
  endtask

  task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = we;
    bus.cpu_req_addr  = a;
    bus.cpu_req_wdata = wd;
    bus.cpu_req_wstrb = st;
  endtask

  task automatic finish_txn();
    chk("resp_seen", 128'(q.size()), 128'(0));
    chk("update_count", 128'(upd_cnt), 128'(m_upd));
    chk_outputs();
  endtask

  // Called at a negedge; returns at the earliest negedge a new request may be driven.
  task automatic txn(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
    exp_t e;
    model_access(we, a, wd, st, e.rd, e.er);
    e.cyc = cyc + L;
    q.push_back(e);
    drive(we, a, wd, st);
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    repeat (L) @(negedge clk);
    finish_txn();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] a, wd;
    logic [3:0]  st;
    bit          we;
    exp_t        e;

    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_we    = 1'b0;
    bus.cpu_req_addr  = 32'd0;
    bus.cpu_req_wdata = 32'd0;
    bus.cpu_req_wstrb = 4'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_resp_valid", 128'(bus.cpu_resp_valid), 128'(0));
    chk("rst_resp_rdata", bus.cpu_resp_rdata, 128'(0));
    chk("rst_resp_err", 128'(bus.cpu_resp_err), 128'(0));
    chk("rst_update", 128'(policy_update), 128'(0));
    chk_outputs();

    // Random traffic; early CTRL writes avoid setting LOCK so policy writes get exercised.
    for (int i = 0; i < 150; i++) begin
      a  = 32'h1004_0000 | (32'($urandom_range(0, 63)) << 2);
      if ($urandom_range(0, 9) == 0) a = $urandom;
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      st = 4'($urandom_range(0, 15));
      if (a[7:0] == 8'h14 && i < 130) wd[0] = 1'b0;
      txn(we, a, wd, st);
    end

    // Reset while the response is still in WAIT: the pending pulse must vanish.
    txn(1'b1, 32'h1004_0000, 32'h1234_5678, 4'hF);
    drive(1'b0, 32'h1004_0000, 32'd0, 4'd0);
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (L + 2) @(negedge clk);
    finish_txn();

    // Directed sequence from reset.
    txn(1'b0, 32'h1004_0024, 32'd0, 4'd0);
    txn(1'b1, 32'h1004_0010, 32'hA5A5_0001, 4'hF);
    txn(1'b0, 32'h1004_0010, 32'd0, 4'd0);
    chk("hash_value", policy_hash, 128'(32'hA5A5_0001));
    txn(1'b1, 32'h1004_0010, 32'h0000_00FF, 4'h1);
    txn(1'b0, 32'h1004_0010, 32'd0, 4'd0);
    chk("hash_merged", policy_hash, 128'(32'hA5A5_00FF));
    txn(1'b0, 32'h2000_0000, 32'd0, 4'd0);
    txn(1'b1, 32'h1004_0002, 32'hDEAD_BEEF, 4'hF);
    txn(1'b1, 32'h1004_0040, 32'hDEAD_BEEF, 4'hF);
    txn(1'b1, 32'h1004_0008, 32'hDEAD_BEEF, 4'h0);
    txn(1'b1, 32'h1004_0000, 32'h0001_0000, 4'hF);
    txn(1'b1, 32'h1004_0014, 32'h0000_0001, 4'hF);
    chk("locked", 128'(policy_locked), 128'(1));
    txn(1'b1, 32'h1004_0000, 32'h0000_0000, 4'hF);
    chk("allow_frozen", allow_mask, 128'(64'h0000_0000_0001_0000));
    txn(1'b0, 32'h1004_0018, 32'd0, 4'd0);

    // Back-to-back request: the second one is dropped and sets DROP.
    model_access(1'b0, 32'h1004_0010, 32'd0, 4'd0, e.rd, e.er);
    e.cyc = cyc + L;
    q.push_back(e);
    drive(1'b0, 32'h1004_0010, 32'd0, 4'd0);
    @(negedge clk);
    drive(1'b1, 32'h1004_0018, 32'h0000_0002, 4'hF);
    m_drop = 1'b1;
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
    repeat (L - 1) @(negedge clk);
    finish_txn();
    txn(1'b0, 32'h1004_0018, 32'd0, 4'd0);
    txn(1'b1, 32'h1004_0018, 32'h0000_0002, 4'hF);
    txn(1'b0, 32'h1004_0018, 32'd0, 4'd0);
    txn(1'b1, 32'h1004_0018, 32'h0000_0000, 4'hF);

    repeat (4) @(negedge clk);
    chk("queue_empty", 128'(q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
